// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter and serial slave router for the bit-serial bus.
// Grants the bus, captures the slave-select prefix, then wires master and slave streams.
module bus_arbiter #(
    parameter int NUM_SLAVES = 3,
    parameter int SID_W      = 2,
    parameter int TIMEOUT    = 8
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [1:0]            M_BREQ,
    output logic [1:0]            M_GRANT,
    input  logic [1:0]            M_VALID,
    input  logic [1:0]            M_DOUT,
    input  logic [1:0]            M_RW,
    output logic [1:0]            M_DIN,
    output logic [1:0]            M_ACK,
    output logic [1:0]            M_SBSY,
    output logic [1:0]            M_ERR,
    output logic [NUM_SLAVES-1:0] S_AD_SEL,
    output logic                  S_RW,
    output logic                  S_BUS_OUT,
    input  logic [NUM_SLAVES-1:0] S_BUS_IN,
    input  logic [NUM_SLAVES-1:0] S_ACK,
    input  logic [NUM_SLAVES-1:0] S_SBSY
);

    localparam int BW = $clog2(SID_W + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SID_W:0] NS_L = (SID_W + 1)'(NUM_SLAVES);

    typedef enum logic [1:0] {
        IDLE,
        SID,
        CONNECT
    } state_t;

    state_t           state;
    logic [1:0]       grant;
    logic [1:0]       err;
    logic             ptr;
    logic             gsel;
    logic [SID_W-1:0] sid;
    logic [BW-1:0]    bit_cnt;
    logic [TW-1:0]    to_cnt;

    logic             v_g;
    logic             d_g;
    logic             rw_g;
    logic             breq_g;
    logic             winner;
    logic [SID_W-1:0] sid_nxt;
    logic             sel_in;
    logic             sel_ack;
    logic             sel_bsy;
    logic             in_conn;

    always_comb begin
        v_g     = M_VALID[gsel];
        d_g     = M_DOUT[gsel];
        rw_g    = M_RW[gsel];
        breq_g  = M_BREQ[gsel];
        in_conn = (state == CONNECT);
        // on a tie the master that did not win last time goes next
        winner  = (M_BREQ == 2'b11) ? ~ptr : M_BREQ[1];
        sid_nxt = (sid >> 1) | (SID_W'(d_g) << (SID_W - 1));
        sel_in  = 1'b0;
        sel_ack = 1'b0;
        sel_bsy = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sid == SID_W'(i)) begin
                sel_in  = S_BUS_IN[i];
                sel_ack = S_ACK[i];
                sel_bsy = S_SBSY[i];
            end
        end
    end

    always_comb begin
        S_AD_SEL  = '0;
        S_RW      = 1'b0;
        S_BUS_OUT = 1'b0;
        M_DIN     = 2'b00;
        M_ACK     = 2'b00;
        M_SBSY    = 2'b00;
        if (in_conn) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (sid == SID_W'(i)) begin
                    S_AD_SEL[i] = v_g;
                end
            end
            S_RW         = rw_g;
            S_BUS_OUT    = d_g;
            M_DIN[gsel]  = sel_in;
            M_ACK[gsel]  = sel_ack;
            M_SBSY[gsel] = sel_bsy;
        end
    end

    assign M_GRANT = grant;
    assign M_ERR   = err;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state   <= IDLE;
            grant   <= 2'b00;
            err     <= 2'b00;
            ptr     <= 1'b1;
            gsel    <= 1'b0;
            sid     <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            err <= 2'b00;
            unique case (state)
                IDLE: begin
                    if (|M_BREQ) begin
                        grant   <= winner ? 2'b10 : 2'b01;
                        ptr     <= winner;
                        gsel    <= winner;
                        sid     <= '0;
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                        state   <= SID;
                    end
                end
                SID: begin
                    if (!breq_g) begin
                        grant <= 2'b00;
                        state <= IDLE;
                    end else if (v_g) begin
                        sid     <= sid_nxt;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(SID_W - 1)) begin
                            if ({1'b0, sid_nxt} < NS_L) begin
                                to_cnt <= '0;
                                state  <= CONNECT;
                            end else begin
                                err   <= gsel ? 2'b10 : 2'b01;
                                grant <= 2'b00;
                                state <= IDLE;
                            end
                        end
                    end
                end
                CONNECT: begin
                    if (!breq_g || (!v_g && !sel_bsy)) begin
                        grant <= 2'b00;
                        state <= IDLE;
                    end else if (sel_bsy) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                        err   <= gsel ? 2'b10 : 2'b01;
                        grant <= 2'b00;
                        state <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: grant, routing, round-robin, errors, reset.
module tb_bus_arbiter;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic [1:0] M_BREQ;
    logic [1:0] M_GRANT;
    logic [1:0] M_VALID;
    logic [1:0] M_DOUT;
    logic [1:0] M_RW;
    logic [1:0] M_DIN;
    logic [1:0] M_ACK;
    logic [1:0] M_SBSY;
    logic [1:0] M_ERR;
    logic [2:0] S_AD_SEL;
    logic       S_RW;
    logic       S_BUS_OUT;
    logic [2:0] S_BUS_IN;
    logic [2:0] S_ACK;
    logic [2:0] S_SBSY;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(
        .NUM_SLAVES(3),
        .SID_W(2),
        .TIMEOUT(8)
    ) dut (
        .CLK(CLK),
        .RSTN(RSTN),
        .M_BREQ(M_BREQ),
        .M_GRANT(M_GRANT),
        .M_VALID(M_VALID),
        .M_DOUT(M_DOUT),
        .M_RW(M_RW),
        .M_DIN(M_DIN),
        .M_ACK(M_ACK),
        .M_SBSY(M_SBSY),
        .M_ERR(M_ERR),
        .S_AD_SEL(S_AD_SEL),
        .S_RW(S_RW),
        .S_BUS_OUT(S_BUS_OUT),
        .S_BUS_IN(S_BUS_IN),
        .S_ACK(S_ACK),
        .S_SBSY(S_SBSY)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // guard cycle after the grant, then the prefix LSB first
    task automatic send_sid(input int m, input logic [1:0] s);
        step();
        for (int i = 0; i < 2; i++) begin
            M_VALID[m] = 1'b1;
            M_DOUT[m]  = s[i];
            #1;
            chk("sid_nosel", 8'(S_AD_SEL), 8'h0);
            step();
        end
    endtask

    initial begin
        logic [3:0] wpat;
        logic [7:0] rpat;
        RSTN     = 1'b0;
        M_BREQ   = 2'b00;
        M_VALID  = 2'b00;
        M_DOUT   = 2'b00;
        M_RW     = 2'b00;
        S_BUS_IN = 3'b000;
        S_ACK    = 3'b000;
        S_SBSY   = 3'b000;
        step();
        chk("rst_grant", 8'(M_GRANT), 8'h0);
        chk("rst_err", 8'(M_ERR), 8'h0);
        chk("rst_sel", 8'(S_AD_SEL), 8'h0);
        chk("rst_din", 8'(M_DIN), 8'h0);
        RSTN = 1'b1;

        // single write: master 0 -> slave 1
        M_BREQ = 2'b01;
        M_RW   = 2'b01;
        step();
        chk("wr_grant", 8'(M_GRANT), 8'h1);
        send_sid(0, 2'b01);
        wpat = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            M_VALID[0] = 1'b1;
            M_DOUT[0]  = wpat[i];
            S_SBSY     = 3'b111;
            S_ACK      = {1'b1, wpat[i], 1'b1};
            #1;
            chk("wr_sel", 8'(S_AD_SEL), 8'h2);
            chk("wr_bus", 8'(S_BUS_OUT), 8'(wpat[i]));
            chk("wr_rw", 8'(S_RW), 8'h1);
            chk("wr_ack", 8'(M_ACK), 8'({1'b0, wpat[i]}));
            chk("wr_sbsy", 8'(M_SBSY), 8'h1);
            step();
        end
        M_VALID = 2'b00;
        M_DOUT  = 2'b00;
        S_ACK   = 3'b000;
        S_SBSY  = 3'b010;
        #1;
        chk("wr_sel_lo", 8'(S_AD_SEL), 8'h0);
        step();
        chk("wr_hold", 8'(M_GRANT), 8'h1);
        S_SBSY = 3'b000;
        step();
        chk("wr_release", 8'(M_GRANT), 8'h0);
        M_BREQ = 2'b00;
        M_RW   = 2'b00;
        step();
        chk("wr_idle", 8'(M_GRANT), 8'h0);

        // round-robin from reset, both requesting
        RSTN = 1'b0;
        step();
        RSTN   = 1'b1;
        M_BREQ = 2'b11;
        step();
        chk("rr_g0", 8'(M_GRANT), 8'h1);
        send_sid(0, 2'b00);
        step();
        M_VALID = 2'b00;
        M_DOUT  = 2'b00;
        step();
        chk("rr_gap0", 8'(M_GRANT), 8'h0);
        step();
        chk("rr_g1", 8'(M_GRANT), 8'h2);
        send_sid(1, 2'b10);
        step();
        M_VALID = 2'b00;
        M_DOUT  = 2'b00;
        step();
        chk("rr_gap1", 8'(M_GRANT), 8'h0);
        step();
        chk("rr_g2", 8'(M_GRANT), 8'h1);
        send_sid(0, 2'b01);
        step();
        M_VALID = 2'b00;
        M_DOUT  = 2'b00;
        step();
        chk("rr_gap2", 8'(M_GRANT), 8'h0);
        step();
        chk("rr_g3", 8'(M_GRANT), 8'h2);
        send_sid(1, 2'b00);
        M_VALID = 2'b00;
        M_DOUT  = 2'b00;
        M_BREQ  = 2'b00;
        step();
        chk("rr_end", 8'(M_GRANT), 8'h0);

        // read: master 1 <- slave 2
        M_BREQ = 2'b10;
        step();
        chk("rd_grant", 8'(M_GRANT), 8'h2);
        send_sid(1, 2'b10);
        rpat = 8'b1001_1101;
        for (int i = 0; i < 8; i++) begin
            M_VALID[1] = 1'b1;
            M_DOUT[1]  = 1'b0;
            S_SBSY     = 3'b100;
            S_BUS_IN   = {rpat[i], 2'b11};
            #1;
            chk("rd_din", 8'(M_DIN), 8'({rpat[i], 1'b0}));
            chk("rd_sel", 8'(S_AD_SEL), 8'h4);
            chk("rd_rw", 8'(S_RW), 8'h0);
            step();
        end
        M_VALID  = 2'b00;
        S_SBSY   = 3'b000;
        S_BUS_IN = 3'b000;
        step();
        chk("rd_release", 8'(M_GRANT), 8'h0);
        M_BREQ = 2'b00;
        step();

        // invalid sid = 3
        M_BREQ = 2'b01;
        step();
        chk("bad_grant", 8'(M_GRANT), 8'h1);
        send_sid(0, 2'b11);
        chk("bad_err", 8'(M_ERR), 8'h1);
        chk("bad_gclr", 8'(M_GRANT), 8'h0);
        chk("bad_sel", 8'(S_AD_SEL), 8'h0);
        M_BREQ  = 2'b00;
        M_VALID = 2'b00;
        M_DOUT  = 2'b00;
        step();
        chk("bad_err_lo", 8'(M_ERR), 8'h0);

        // timeout: slave 0 never busy
        M_BREQ = 2'b10;
        step();
        chk("to_grant", 8'(M_GRANT), 8'h2);
        send_sid(1, 2'b00);
        for (int i = 0; i < 8; i++) begin
            M_VALID[1] = 1'b1;
            S_SBSY     = 3'b000;
            #1;
            chk("to_sel", 8'(S_AD_SEL), 8'h1);
            chk("to_noerr", 8'(M_ERR), 8'h0);
            step();
        end
        chk("to_err", 8'(M_ERR), 8'h2);
        chk("to_gclr", 8'(M_GRANT), 8'h0);
        chk("to_sel_lo", 8'(S_AD_SEL), 8'h0);
        M_BREQ  = 2'b00;
        M_VALID = 2'b00;
        step();
        chk("to_err_lo", 8'(M_ERR), 8'h0);

        // reset in the middle of a transfer
        M_BREQ = 2'b01;
        step();
        chk("rs_grant", 8'(M_GRANT), 8'h1);
        send_sid(0, 2'b01);
        M_VALID[0] = 1'b1;
        M_DOUT[0]  = 1'b1;
        S_SBSY     = 3'b010;
        S_ACK      = 3'b010;
        #1;
        chk("rs_sel", 8'(S_AD_SEL), 8'h2);
        step();
        RSTN   = 1'b0;
        M_BREQ = 2'b11;
        step();
        chk("rs_gclr", 8'(M_GRANT), 8'h0);
        chk("rs_sel_lo", 8'(S_AD_SEL), 8'h0);
        chk("rs_bus", 8'(S_BUS_OUT), 8'h0);
        chk("rs_ack", 8'(M_ACK), 8'h0);
        chk("rs_sbsy", 8'(M_SBSY), 8'h0);
        chk("rs_err", 8'(M_ERR), 8'h0);
        RSTN    = 1'b1;
        M_VALID = 2'b00;
        M_DOUT  = 2'b00;
        S_SBSY  = 3'b000;
        S_ACK   = 3'b000;
        step();
        chk("rs_tie", 8'(M_GRANT), 8'h1);
        M_BREQ = 2'b00;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
